// File: rtl/demux32bit_1to2_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux32bit_1to2_reg
// Description : Registered 1-to-2 word demultiplexer. It has one single-entry
//               holding register per output port, valid/ready handshakes on
//               each port, and a wrapping delivery counter per port.
// Revision    : 1.0 - initial release
// ============================================================================
module demux32bit_1to2_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] outA_data,
    output logic             outA_valid,
    input  logic             outA_ready,
    output logic [WIDTH-1:0] outB_data,
    output logic             outB_valid,
    input  logic             outB_ready,
    output logic [CNT_W-1:0] cntA,
    output logic [CNT_W-1:0] cntB
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [WIDTH-1:0] r_a_data;
    logic             r_a_valid;
    logic [CNT_W-1:0] r_a_cnt;
    logic [WIDTH-1:0] r_b_data;
    logic             r_b_valid;
    logic [CNT_W-1:0] r_b_cnt;

    logic w_drain_a;
    logic w_drain_b;
    logic w_free_a;
    logic w_free_b;
    logic w_accept;
    logic w_load_a;
    logic w_load_b;

    assign w_drain_a = r_a_valid & outA_ready;
    assign w_drain_b = r_b_valid & outB_ready;

    // A port is free when it is empty or is being emptied on this same edge.
    assign w_free_a  = ~r_a_valid | outA_ready;
    assign w_free_b  = ~r_b_valid | outB_ready;

    // Only the selected port gates the producer.
    assign in_ready  = in_sel ? w_free_b : w_free_a;
    assign w_accept  = in_valid & in_ready;
    assign w_load_a  = w_accept & ~in_sel;
    assign w_load_b  = w_accept &  in_sel;

    // Port A holding register and delivery counter
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_a_data  <= '0;
            r_a_valid <= 1'b0;
            r_a_cnt   <= '0;
        end else begin
            if (w_load_a) begin
                r_a_data  <= in_data;
                r_a_valid <= 1'b1;
            end else if (w_drain_a) begin
                r_a_valid <= 1'b0;
            end
            if (w_drain_a) begin
                r_a_cnt <= r_a_cnt + c_cnt_one;
            end
        end
    end

    // Port B holding register and delivery counter
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_b_data  <= '0;
            r_b_valid <= 1'b0;
            r_b_cnt   <= '0;
        end else begin
            if (w_load_b) begin
                r_b_data  <= in_data;
                r_b_valid <= 1'b1;
            end else if (w_drain_b) begin
                r_b_valid <= 1'b0;
            end
            if (w_drain_b) begin
                r_b_cnt <= r_b_cnt + c_cnt_one;
            end
        end
    end

    assign outA_data  = r_a_data;
    assign outA_valid = r_a_valid;
    assign outB_data  = r_b_data;
    assign outB_valid = r_b_valid;
    assign cntA       = r_a_cnt;
    assign cntB       = r_b_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux32bit_1to2_reg.sv
`default_nettype none
// Directed testbench for demux32bit_1to2_reg with a per-port streaming scoreboard.
module tb_demux32bit_1to2_reg;

    logic        Clk;
    logic        Rst;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] outA_data;
    logic        outA_valid;
    logic        outA_ready;
    logic [31:0] outB_data;
    logic        outB_valid;
    logic        outB_ready;
    logic [15:0] cntA;
    logic [15:0] cntB;

    int checks = 0;
    int errors = 0;

    demux32bit_1to2_reg #(.WIDTH(32), .CNT_W(16)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .outA_data  (outA_data),
        .outA_valid (outA_valid),
        .outA_ready (outA_ready),
        .outB_data  (outB_data),
        .outB_valid (outB_valid),
        .outB_ready (outB_ready),
        .cntA       (cntA),
        .cntB       (cntB)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    initial begin : main
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        logic        exp_rdy;
        int          sent;
        int          cycles;
        int          na;
        int          nb;

        // Reset held two cycles with a word offered; it must be discarded
        Rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hFFFF_FFFF;
        outA_ready = 1'b0; outB_ready = 1'b0;
        cyc(); cyc();
        chk("rst_a_valid", outA_valid, 1'b0);
        chk("rst_b_valid", outB_valid, 1'b0);
        chk("rst_a_data", outA_data, 32'h0);
        chk("rst_b_data", outB_data, 32'h0);
        chk("rst_cntA", cntA, 16'h0);
        chk("rst_cntB", cntB, 16'h0);
        Rst = 1'b0; in_valid = 1'b0; in_sel = 1'b0; #1;
        chk("rst_ready_sel0", in_ready, 1'b1);
        in_sel = 1'b1; #1;
        chk("rst_ready_sel1", in_ready, 1'b1);

        // Basic steer
        outA_ready = 1'b1; outB_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD_BEEF; #1;
        chk("basic_ready_a", in_ready, 1'b1);
        cyc();
        chk("basic_a_valid", outA_valid, 1'b1);
        chk("basic_a_data", outA_data, 32'hDEAD_BEEF);
        chk("basic_b_idle", outB_valid, 1'b0);
        in_sel = 1'b1; in_data = 32'h1234_5678;
        cyc();
        chk("basic_a_drained", outA_valid, 1'b0);
        chk("basic_b_valid", outB_valid, 1'b1);
        chk("basic_b_data", outB_data, 32'h1234_5678);
        chk("basic_cntA", cntA, 16'd1);
        in_valid = 1'b0;
        cyc();
        chk("basic_b_drained", outB_valid, 1'b0);
        chk("basic_cntB", cntB, 16'd1);

        // Back-pressure on A must not block traffic to B
        outA_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h1;
        cyc();
        chk("bp_a_data1", outA_data, 32'h1);
        in_data = 32'h2; #1;
        chk("bp_ready_a_full", in_ready, 1'b0);
        cyc();
        chk("bp_a_holds", outA_data, 32'h1);
        chk("bp_a_valid", outA_valid, 1'b1);
        in_sel = 1'b1; in_data = 32'h3; #1;
        chk("bp_ready_b", in_ready, 1'b1);
        cyc();
        chk("bp_b_data", outB_data, 32'h3);
        chk("bp_b_valid", outB_valid, 1'b1);
        chk("bp_a_still", outA_data, 32'h1);
        in_sel = 1'b0; in_data = 32'h2; outA_ready = 1'b1; #1;
        chk("bp_ready_a_release", in_ready, 1'b1);
        cyc();
        chk("bp_a_data2", outA_data, 32'h2);
        chk("bp_a_valid2", outA_valid, 1'b1);
        chk("bp_cntA", cntA, 16'd2);
        chk("bp_cntB", cntB, 16'd2);
        in_valid = 1'b0;
        cyc();
        chk("bp_cntA_final", cntA, 16'd3);
        chk("bp_a_empty", outA_valid, 1'b0);

        // Simultaneous drain and load on A
        outA_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hAAAA_0000;
        cyc();
        chk("sim_a_first", outA_data, 32'hAAAA_0000);
        outA_ready = 1'b1; in_data = 32'hBBBB_0000; #1;
        chk("sim_ready", in_ready, 1'b1);
        cyc();
        chk("sim_a_data", outA_data, 32'hBBBB_0000);
        chk("sim_a_valid", outA_valid, 1'b1);
        chk("sim_cntA", cntA, 16'd4);
        in_valid = 1'b0;
        cyc();
        chk("sim_cntA_final", cntA, 16'd5);

        // Random streaming against per-port scoreboards
        Rst = 1'b1; cyc(); Rst = 1'b0;
        sent = 0; cycles = 0; na = 0; nb = 0;
        while ((sent < 1000 || qa.size() != 0 || qb.size() != 0) && cycles < 20000) begin
            outA_ready = ($urandom_range(3) != 0);
            outB_ready = ($urandom_range(3) != 0);
            if (sent < 1000) begin
                in_valid = 1'b1;
                in_sel   = 1'($urandom_range(1));
                in_data  = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            exp_rdy = in_sel ? (qb.size() == 0 || outB_ready) : (qa.size() == 0 || outA_ready);
            chk("stream_in_ready", in_ready, exp_rdy);
            chk("stream_a_valid", outA_valid, qa.size() != 0);
            chk("stream_b_valid", outB_valid, qb.size() != 0);
            if (outA_ready && qa.size() != 0) begin
                chk("stream_a_data", outA_data, qa.pop_front());
                na++;
            end
            if (outB_ready && qb.size() != 0) begin
                chk("stream_b_data", outB_data, qb.pop_front());
                nb++;
            end
            if (in_valid && exp_rdy) begin
                if (in_sel) qb.push_back(in_data);
                else        qa.push_back(in_data);
                sent++;
            end
            cyc();
            cycles++;
        end
        chk("stream_timeout", cycles < 20000, 1'b1);
        chk("stream_cntA", cntA, na);
        chk("stream_cntB", cntB, nb);
        chk("stream_total", na + nb, 1000);

        // Counter wrap on A
        in_valid = 1'b0; Rst = 1'b1; cyc(); Rst = 1'b0;
        outA_ready = 1'b1; outB_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            in_data = i;
            cyc();
        end
        chk("wrap_cntA_max", cntA, 16'hFFFF);
        chk("wrap_a_valid", outA_valid, 1'b1);
        in_valid = 1'b0;
        cyc();
        chk("wrap_cntA_zero", cntA, 16'h0000);

        // Reset while both ports are full
        outA_ready = 1'b0; outB_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h11;
        cyc();
        in_sel = 1'b1; in_data = 32'h22; outA_ready = 1'b1;
        cyc();
        outA_ready = 1'b0; in_sel = 1'b0; in_data = 32'h33;
        cyc();
        chk("mid_a_full", outA_valid, 1'b1);
        chk("mid_b_full", outB_valid, 1'b1);
        chk("mid_cntA", cntA, 16'd1);
        Rst = 1'b1; in_valid = 1'b1; outA_ready = 1'b1; outB_ready = 1'b1; in_data = 32'h44;
        cyc();
        chk("mid_rst_a_valid", outA_valid, 1'b0);
        chk("mid_rst_b_valid", outB_valid, 1'b0);
        chk("mid_rst_a_data", outA_data, 32'h0);
        chk("mid_rst_b_data", outB_data, 32'h0);
        chk("mid_rst_cntA", cntA, 16'h0);
        chk("mid_rst_cntB", cntB, 16'h0);
        Rst = 1'b0; in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux32bit_1to2_reg.md
# demux32bit_1to2_reg

Registered 1-to-2 demultiplexer for 32-bit words: the distribution counterpart of the 2-to-1 word multiplexers in the datapath. A single producer presents a word and a select bit, and the block steers it into one of two single-entry output holding registers, A or B, each with its own valid/ready handshake toward a downstream consumer. Per-port 16-bit delivery counters support debug and verification.

## Interface
- WIDTH, 32, data word width.
- CNT_W, 16, width of each delivery counter.

- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  1  0 = route to port A, 1 = route to port B.
- in_valid  input  1  producer offers in_data/in_sel this cycle.
- in_ready  output  1  block accepts the offered word this cycle (combinational).
- outA_data  output  WIDTH  port A held word.
- outA_valid  output  1  port A holds an undelivered word.
- outA_ready  input  1  port A consumer takes the word this cycle.
- outB_data  output  WIDTH  port B held word.
- outB_valid  output  1  port B holds an undelivered word.
- outB_ready  input  1  port B consumer takes the word this cycle.
- cntA  output  CNT_W  number of words delivered on port A (wraps).
- cntB  output  CNT_W  number of words delivered on port B (wraps).

## Operation
- Each port X in {A, B} has one holding register (outX_data, outX_valid).
- drainX = outX_valid & outX_ready (delivery on port X).
- freeX = ~outX_valid | outX_ready (register X can take a word this cycle).
- in_ready = in_sel ? freeB : freeA. Depends only on in_sel and the selected port; the unselected port never stalls the producer.
- accept = in_valid & in_ready. loadA = accept & ~in_sel; loadB = accept & in_sel.
- Per port, on each rising edge (Rst low):
  - loadX: outX_data <= in_data, outX_valid <= 1 (covers simultaneous drain + load: valid stays 1, new word replaces delivered word).
  - else drainX: outX_valid <= 0, outX_data holds its last value.
  - else: no change.
- A word is never duplicated, dropped or sent to the unselected port. Words on one port are delivered in acceptance order.
- Both ports may drain in the same cycle; at most one port loads per cycle.
- Counters: cntX <= cntX + 1 on drainX, modulo 2^CNT_W (0xFFFF -> 0x0000 for CNT_W = 16).
- When in_valid = 0, in_sel and in_data are don't-care and cause no state change. in_ready is still driven from in_sel.
- Consumer ready while outX_valid = 0 has no effect.

## Timing
- Reset (Rst = 1 at a rising edge): outA_valid = outB_valid = 0, outA_data = outB_data = 0, cntA = cntB = 0. Reset overrides any simultaneous accept or drain; a word in flight is discarded.
- After reset: in_ready = 1 for either in_sel value.
- Latency: word accepted at edge N is visible on outX_data/outX_valid after edge N (cycle N+1), earliest delivery at edge N+1.
- Throughput: one word per cycle on a port whose consumer holds ready high. A full port with ready low deasserts in_ready for that port's select only.
- in_ready is combinational from in_sel, outX_valid and outX_ready. No combinational path from in_data to any output.
- Outputs other than in_ready are registered.

## Test plan
- Reset: drive Rst = 1 for 2 cycles with in_valid = 1 -> both valids 0, data 0, cntA = cntB = 0, in_ready = 1 after release.
- Basic steer: accept 0xDEADBEEF with sel = 0, then 0x12345678 with sel = 1, both readies high -> outA_data = 0xDEADBEEF valid for one cycle, then outB_data = 0x12345678. cntA = 1, cntB = 1.
- Back-pressure isolation: outA_ready = 0, send 0x1 to A, then 0x2 (sel = 0) -> in_ready = 0, A holds 0x1. Switch to sel = 1 with 0x3 -> accepted, appears on B. Raise outA_ready -> 0x1 delivered, then 0x2 accepted.
- Simultaneous drain and load: A full with 0xAAAA0000, outA_ready = 1, offer 0xBBBB0000 to A same cycle -> in_ready = 1, next cycle outA_data = 0xBBBB0000, outA_valid = 1, cntA incremented by 1.
- Streaming: 1000 random words with random sel and random per-port ready -> scoreboard per port matches in order, cntA + cntB = 1000, no word lost or duplicated.
- Counter wrap and mid-operation reset: preload 65535 deliveries on A -> next delivery gives cntA = 0x0000. Then assert Rst while both ports are full -> both valids 0 and counters 0 after the edge.
